// File: rtl/tt_um_leg_solver.sv
// tt_um_leg_solver: given hypotenuse c (ui_in) and leg a (uio_in), computes
// the other leg b = sqrt(c^2 - a^2) with a restoring bit-serial square root.
// Define LEG_ROUND_EN to round the root to nearest instead of flooring it.
module tt_um_leg_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned W  = 8;       // operand / result width
  localparam int unsigned DW = 2 * W;   // radicand width
  localparam int unsigned RW = W + 2;   // remainder width (rem <= 2r)
  localparam int unsigned TW = RW + 2;  // trial subtraction width
  localparam int unsigned CW = 3;       // iteration counter width

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    c_q, c_d;
  logic [W-1:0]    a_q, a_d;
  logic [DW-1:0]   d_q, d_d;
  logic [W-1:0]    r_q, r_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    uo_q, uo_d;

  logic [DW-1:0]   csq, asq;
  logic [TW-1:0]   tmp, trial;
  logic [W-1:0]    result;

  assign uo_out  = uo_q;
  assign uio_out = '0;
  assign uio_oe  = '0;

  // Next-state and datapath: defaults hold every register, each state overrides.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    a_d     = a_q;
    d_d     = d_q;
    r_d     = r_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    uo_d    = uo_q;

    csq   = DW'(c_q) * DW'(c_q);
    asq   = DW'(a_q) * DW'(a_q);
    // Bring down the next two radicand bits and try subtracting 4r+1.
    tmp   = {rem_q, d_q[DW-1:DW-2]};
    trial = {2'b00, r_q, 2'b01};

`ifdef LEG_ROUND_EN
    // Round to nearest: bump when the remainder exceeds r; saturate for safety.
    if (RW'(r_q) < rem_q) result = (r_q == {W{1'b1}}) ? r_q : r_q + W'(1);
    else                  result = r_q;
`else
    result = r_q;
`endif

    case (state_q)
      IDLE: begin
        if (ui_in != c_q || uio_in != a_q) begin
          c_d     = ui_in;
          a_d     = uio_in;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        d_d     = (a_q > c_q) ? '0 : csq - asq;
        r_d     = '0;
        rem_d   = '0;
        cnt_d   = CW'(7);
        state_d = ROOT;
      end
      ROOT: begin
        d_d = d_q << 2;
        if (tmp >= trial) begin
          rem_d = RW'(tmp - trial);
          r_d   = {r_q[W-2:0], 1'b1};
        end else begin
          rem_d = RW'(tmp);
          r_d   = {r_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        uo_d    = result;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers: synchronous reset wins, ena=0 freezes all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      a_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      uo_q    <= '0;
    end else if (ena) begin
      state_q <= state_d;
      c_q     <= c_d;
      a_q     <= a_d;
      d_q     <= d_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      uo_q    <= uo_d;
    end
  end

endmodule

// File: tb/tb_tt_um_leg_solver.sv
// Bench for tt_um_leg_solver: a timeline model (capture, then result 10 edges
// later) checked every cycle, plus directed cases with literal expectations.
module tb_tt_um_leg_solver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_bad = 0;
  bit running = 1'b0;

  // Model state: held operands, edges left until result, expected output.
  int         m_c = 0, m_a = 0, m_left = 0;
  logic [7:0] m_exp = 8'd0;

  tt_um_leg_solver dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Other leg from plain integer arithmetic.
  function automatic logic [7:0] leg(input int c, input int a);
    int d, r;
    if (a >= c) return 8'd0;
    d = c * c - a * a;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
`ifdef LEG_ROUND_EN
    if (d - r * r > r && r < 255) r++;
`endif
    return 8'(r);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model advanced on each active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_c = 0; m_a = 0; m_left = 0; m_exp = 8'd0;
    end else if (ena) begin
      if (m_left == 0) begin
        if (int'(ui_in) != m_c || int'(uio_in) != m_a) begin
          m_c = int'(ui_in); m_a = int'(uio_in); m_left = 10;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_exp = leg(m_c, m_a);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      chk("model_uo_out", uo_out, m_exp);
      chk("uio_out", uio_out, 8'h00);
      chk("uio_oe", uio_oe, 8'h00);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ui_in = 8'd0; uio_in = 8'd0; ena = 1'b1;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Apply operands now (at a negedge, block idle); check hold and result time.
  task automatic run_case(input string name, input int c, input int a,
                          input logic [7:0] prev, input logic [7:0] want);
    ui_in = 8'(c); uio_in = 8'(a);
    cyc(10);
    chk({name, "_hold"}, uo_out, prev);
    cyc(1);
    chk(name, uo_out, want);
  endtask

  initial begin
    logic [7:0] w24;
`ifdef LEG_ROUND_EN
    w24 = 8'd5;
`else
    w24 = 8'd4;
`endif
    rst_n = 1'b0;
    @(posedge clk);
    running = 1'b1;
    do_reset();
    chk("reset_uo_out", uo_out, 8'd0);

    // Directed sequence; each result appears 10 edges after capture.
    run_case("c5_a3", 5, 3, 8'd0, 8'd4);
    run_case("c13_a5", 13, 5, 8'd4, 8'd12);
    run_case("c10_a6", 10, 6, 8'd12, 8'd8);
    run_case("c255_a0", 255, 0, 8'd8, 8'd255);
    run_case("c3_a5", 3, 5, 8'd255, 8'd0);
    run_case("c5_a1", 5, 1, 8'd0, w24);
    run_case("c10_a9", 10, 9, w24, 8'd4);
    run_case("c7_a7", 7, 7, 8'd4, 8'd0);

    // Input change mid-computation is ignored until the block returns to idle.
    ui_in = 8'd5; uio_in = 8'd3;
    cyc(3);
    ui_in = 8'd10; uio_in = 8'd8;
    cyc(8);
    chk("midchg_first", uo_out, 8'd4);
    cyc(10);
    chk("midchg_hold", uo_out, 8'd4);
    cyc(1);
    chk("midchg_second", uo_out, 8'd6);

    // Reset during ROOT aborts; recapture on the first edge after release.
    do_reset();
    ui_in = 8'd13; uio_in = 8'd5;
    cyc(5);
    rst_n = 1'b0;
    cyc(1);
    chk("rst_mid_out", uo_out, 8'd0);
    rst_n = 1'b1;
    cyc(10);
    chk("rst_recap_hold", uo_out, 8'd0);
    cyc(1);
    chk("rst_recap_result", uo_out, 8'd12);

    // ena low for 5 edges during ROOT delays the result by exactly 5.
    ui_in = 8'd10; uio_in = 8'd6;
    cyc(4);
    ena = 1'b0;
    cyc(5);
    ena = 1'b1;
    cyc(6);
    chk("ena_hold", uo_out, 8'd12);
    cyc(1);
    chk("ena_result", uo_out, 8'd8);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ui_in = 8'($urandom);
        uio_in = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, int'(ui_in)));
      end
      ena   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    rst_n = 1'b1; ena = 1'b1;
    cyc(12);

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
